kernel_loader: RTL



---
 rtl/kernel_loader_if.sv | 20 ++
 rtl/kernel_loader.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/kernel_loader_if.sv
// kernel_loader_if: coefficient stream (data/valid/ready) into the loader.
interface kernel_loader_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_valid;
  logic                  s_ready;

  modport master (
    output s_data,
    output s_valid,
    input  s_ready
  );

  modport slave (
    input  s_data,
    input  s_valid,
    output s_ready
  );
endinterface

// File: rtl/kernel_loader.sv
// kernel_loader: streams 3x3 kernel coefficients into mem_kernel.
// Optional read-back checksum verify: define KERNEL_LOADER_VERIFY_EN.
module kernel_loader #(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 4,
  parameter int KERNEL_SIZE  = 9,
  parameter int BASE_ADDR    = 0,
  parameter int READ_LATENCY = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  kernel_loader_if.slave        s,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_wren,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] WRITE  = 2'd1;
  localparam logic [1:0] VERIFY = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam logic [ADDR_WIDTH-1:0] BASE_A =
    ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] LAST =
    ADDR_WIDTH'(KERNEL_SIZE - 1);

`ifdef KERNEL_LOADER_VERIFY_EN
  localparam logic [1:0] AFTER_WRITE = VERIFY;
`else
  localparam logic [1:0] AFTER_WRITE = DONE;
`endif

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] idx;
  logic [DATA_WIDTH-1:0] csum;
  logic                  s_ready;
  logic                  beat;

  assign s.s_ready = s_ready;
  assign beat      = s.s_valid & s_ready;

`ifdef KERNEL_LOADER_VERIFY_EN
  localparam logic [ADDR_WIDTH:0] KSZ =
    (ADDR_WIDTH + 1)'(KERNEL_SIZE);
  localparam logic [ADDR_WIDTH:0] KSZ_M1 =
    (ADDR_WIDTH + 1)'(KERNEL_SIZE - 1);

  logic [ADDR_WIDTH:0]   rd_idx;
  logic [READ_LATENCY:0] vpipe;
  logic [READ_LATENCY:0] lpipe;
  logic [DATA_WIDTH-1:0] rsum;
  logic [DATA_WIDTH-1:0] rsum_next;
  logic                  issue;
  logic                  verify_fin;

  assign issue      = (state == VERIFY) && (rd_idx < KSZ);
  assign rsum_next  = rsum + mem_q;
  // lpipe tags the final read so completion needs no return counter
  assign verify_fin = vpipe[READ_LATENCY] & lpipe[READ_LATENCY];

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rd_idx <= '0;
      vpipe  <= '0;
      lpipe  <= '0;
      rsum   <= '0;
      error  <= 1'b0;
    end else begin
      vpipe[0] <= issue;
      lpipe[0] <= issue && (rd_idx == KSZ_M1);
      for (int k = 1; k <= READ_LATENCY; k++) begin
        vpipe[k] <= vpipe[k-1];
        lpipe[k] <= lpipe[k-1];
      end
      if (state != VERIFY) begin
        rd_idx <= '0;
        rsum   <= '0;
      end else begin
        if (issue)
          rd_idx <= rd_idx + 1'b1;
        if (vpipe[READ_LATENCY])
          rsum <= rsum_next;
      end
      if (state == IDLE && start)
        error <= 1'b0;
      else if (verify_fin && rsum_next != csum)
        error <= 1'b1;
    end
  end
`else
  logic unused_q;

  assign error    = 1'b0;
  assign unused_q = ^{mem_q, csum} ^ (READ_LATENCY > 0);
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= IDLE;
      idx         <= '0;
      csum        <= '0;
      s_ready     <= 1'b0;
      mem_address <= '0;
      mem_data    <= '0;
      mem_wren    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      mem_wren <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state   <= WRITE;
            idx     <= '0;
            csum    <= '0;
            s_ready <= 1'b1;
            busy    <= 1'b1;
          end
        end
        WRITE: begin
          if (beat) begin
            mem_address <= BASE_A + idx;
            mem_data    <= s.s_data;
            mem_wren    <= 1'b1;
            csum        <= csum + s.s_data;
            if (idx == LAST) begin
              state   <= AFTER_WRITE;
              s_ready <= 1'b0;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
`ifdef KERNEL_LOADER_VERIFY_EN
        VERIFY: begin
          if (issue)
            mem_address <= BASE_A + rd_idx[ADDR_WIDTH-1:0];
          if (verify_fin) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
`endif
        DONE: begin
          // first DONE cycle raises the pulse, second drops it
          if (!done) begin
            done <= 1'b1;
          end else begin
            done  <= 1'b0;
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          s_ready <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule
